// File: rtl/reorder_buffer_if.sv
// Dispatch, completion, retire and flush signals between the ROB and its
// neighbours. The master modport is the pipeline side; the slave is the ROB.
interface reorder_buffer_if #(
    parameter int NUM_ENTRIES_LOG2 = 3,
    parameter int REG_ADDR_W       = 5,
    parameter int DATA_W           = 32
);
    logic                        dispatch0;
    logic [REG_ADDR_W-1:0]       dispatch_reg0;
    logic                        dispatch1;
    logic [REG_ADDR_W-1:0]       dispatch_reg1;
    logic [NUM_ENTRIES_LOG2-1:0] alloc_idx0;
    logic [NUM_ENTRIES_LOG2-1:0] alloc_idx1;
    logic                        ready0;
    logic                        ready1;

    logic                        complete0;
    logic                        complete1;
    logic [NUM_ENTRIES_LOG2-1:0] complete_idx0;
    logic [NUM_ENTRIES_LOG2-1:0] complete_idx1;
    logic [DATA_W-1:0]           complete_data0;
    logic [DATA_W-1:0]           complete_data1;

    logic                        pop0;
    logic                        pop1;
    logic [REG_ADDR_W-1:0]       pop_reg_addr0;
    logic [REG_ADDR_W-1:0]       pop_reg_addr1;
    logic [NUM_ENTRIES_LOG2-1:0] pop_rob_addr0;
    logic [NUM_ENTRIES_LOG2-1:0] pop_rob_addr1;
    logic [DATA_W-1:0]           pop_data0;
    logic [DATA_W-1:0]           pop_data1;
    logic [NUM_ENTRIES_LOG2-1:0] oldest;

    logic                        flush;
    logic [NUM_ENTRIES_LOG2-1:0] flush_offset;

    modport master (
        output dispatch0, dispatch_reg0, dispatch1, dispatch_reg1,
        output complete0, complete1, complete_idx0, complete_idx1,
        output complete_data0, complete_data1, flush, flush_offset,
        input  alloc_idx0, alloc_idx1, ready0, ready1,
        input  pop0, pop1, pop_reg_addr0, pop_reg_addr1,
        input  pop_rob_addr0, pop_rob_addr1, pop_data0, pop_data1, oldest
    );

    modport slave (
        input  dispatch0, dispatch_reg0, dispatch1, dispatch_reg1,
        input  complete0, complete1, complete_idx0, complete_idx1,
        input  complete_data0, complete_data1, flush, flush_offset,
        output alloc_idx0, alloc_idx1, ready0, ready1,
        output pop0, pop1, pop_reg_addr0, pop_reg_addr1,
        output pop_rob_addr0, pop_rob_addr1, pop_data0, pop_data1, oldest
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: dual dispatch, dual writeback, in-order dual retire
// and mispredict squash of everything younger than the flushing branch.
module reorder_buffer #(
    parameter int NUM_ENTRIES      = 8,
    parameter int NUM_ENTRIES_LOG2 = 3,
    parameter int REG_ADDR_W       = 5,
    parameter int DATA_W           = 32
) (
    input logic             clk,
    input logic             reset,
    reorder_buffer_if.slave bus
);
    localparam int CNT_W = NUM_ENTRIES_LOG2 + 1;
    typedef logic [NUM_ENTRIES_LOG2-1:0] idx_t;
    typedef logic [CNT_W-1:0]            cnt_t;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0] done_q, done_d;
    logic [REG_ADDR_W-1:0]  reg_q  [NUM_ENTRIES];
    logic [REG_ADDR_W-1:0]  reg_d  [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_d [NUM_ENTRIES];
    idx_t                   head_q, head_d;
    idx_t                   tail_q, tail_d;
    cnt_t                   count_q, count_d;

    idx_t head1;
    idx_t tail1;
    logic ready0, ready1;
    logic pop0, pop1;
    logic acc0, acc1;
    cnt_t n_ret, n_acc;
    idx_t off;
    idx_t k;

    assign head1  = head_q + idx_t'(1);
    assign tail1  = tail_q + idx_t'(1);
    assign ready0 = count_q < cnt_t'(NUM_ENTRIES);
    assign ready1 = count_q <= cnt_t'(NUM_ENTRIES - 2);
    assign pop0   = valid_q[head_q] & done_q[head_q];
    assign pop1   = pop0 & valid_q[head1] & done_q[head1];
    // Dispatch is dropped while a flush is in flight.
    assign acc0   = bus.dispatch0 & ready0 & ~bus.flush;
    assign acc1   = acc0 & bus.dispatch1 & ready1;
    assign n_ret  = cnt_t'(pop0) + cnt_t'(pop1);
    assign n_acc  = cnt_t'(acc0) + cnt_t'(acc1);

    assign bus.ready0        = ready0;
    assign bus.ready1        = ready1;
    assign bus.alloc_idx0    = tail_q;
    assign bus.alloc_idx1    = tail1;
    assign bus.oldest        = head_q;
    assign bus.pop0          = pop0;
    assign bus.pop1          = pop1;
    assign bus.pop_rob_addr0 = pop0 ? head_q : '0;
    assign bus.pop_rob_addr1 = pop1 ? head1 : '0;
    assign bus.pop_reg_addr0 = pop0 ? reg_q[head_q] : '0;
    assign bus.pop_reg_addr1 = pop1 ? reg_q[head1] : '0;
    assign bus.pop_data0     = pop0 ? data_q[head_q] : '0;
    assign bus.pop_data1     = pop1 ? data_q[head1] : '0;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        reg_d   = reg_q;
        data_d  = data_q;
        head_d  = head_q + idx_t'(n_ret);
        tail_d  = tail_q;
        count_d = count_q + n_acc - n_ret;
        off     = '0;
        k       = '0;

        // Pipe 1 is applied second so it wins on a same-index collision.
        if (bus.complete0 && valid_q[bus.complete_idx0]) begin
            done_d[bus.complete_idx0] = 1'b1;
            data_d[bus.complete_idx0] = bus.complete_data0;
        end
        if (bus.complete1 && valid_q[bus.complete_idx1]) begin
            done_d[bus.complete_idx1] = 1'b1;
            data_d[bus.complete_idx1] = bus.complete_data1;
        end

        if (pop0) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (pop1) begin
            valid_d[head1] = 1'b0;
            done_d[head1]  = 1'b0;
        end

        if (bus.flush) begin
            tail_d  = head_q + bus.flush_offset + idx_t'(1);
            count_d = cnt_t'(bus.flush_offset) + cnt_t'(1) - n_ret;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                k   = idx_t'(i);
                off = k - head_q;
                if (off > bus.flush_offset) begin
                    valid_d[k] = 1'b0;
                    done_d[k]  = 1'b0;
                end
            end
        end else begin
            if (acc0) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                reg_d[tail_q]   = bus.dispatch_reg0;
            end
            if (acc1) begin
                valid_d[tail1] = 1'b1;
                done_d[tail1]  = 1'b0;
                reg_d[tail1]   = bus.dispatch_reg1;
            end
            tail_d = tail_q + idx_t'(n_acc);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            done_q  <= '0;
            reg_q   <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random stimulus for reorder_buffer, checked against an in-order
// queue model of the buffer contents.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    reorder_buffer_if #(.NUM_ENTRIES_LOG2(3), .REG_ADDR_W(5), .DATA_W(32)) bus ();

    reorder_buffer #(
        .NUM_ENTRIES(8), .NUM_ENTRIES_LOG2(3), .REG_ADDR_W(5), .DATA_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rg;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   mhead = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_complete(input logic [2:0] idx, input logic [31:0] d);
        int pos = (int'(idx) - mhead + 8) % 8;
        if (pos < q.size()) begin
            q[pos].done = 1'b1;
            q[pos].data = d;
        end
    endfunction

    function automatic void model_apply();
        int sz = q.size();
        int n = 0;
        if (sz > 0 && q[0].done) begin
            n = 1;
            if (sz > 1 && q[1].done) n = 2;
        end
        if (bus.complete0) model_complete(bus.complete_idx0, bus.complete_data0);
        if (bus.complete1) model_complete(bus.complete_idx1, bus.complete_data1);
        if (bus.flush) begin
            while (q.size() > int'(bus.flush_offset) + 1) void'(q.pop_back());
        end
        repeat (n) void'(q.pop_front());
        mhead = (mhead + n) % 8;
        if (!bus.flush && bus.dispatch0 && sz < 8) begin
            q.push_back('{rg: bus.dispatch_reg0, done: 1'b0, data: '0});
            if (bus.dispatch1 && sz <= 6)
                q.push_back('{rg: bus.dispatch_reg1, done: 1'b0, data: '0});
        end
    endfunction

    task automatic check_model(input string tag);
        int sz = q.size();
        bit p0 = (sz > 0) && q[0].done;
        bit p1 = p0 && (sz > 1) && q[1].done;
        chk({tag, "_ready0"}, 32'(bus.ready0), 32'(sz < 8));
        chk({tag, "_ready1"}, 32'(bus.ready1), 32'(sz <= 6));
        chk({tag, "_alloc0"}, 32'(bus.alloc_idx0), 32'((mhead + sz) % 8));
        chk({tag, "_alloc1"}, 32'(bus.alloc_idx1), 32'((mhead + sz + 1) % 8));
        chk({tag, "_oldest"}, 32'(bus.oldest), 32'(mhead));
        chk({tag, "_pop0"}, 32'(bus.pop0), 32'(p0));
        chk({tag, "_pop1"}, 32'(bus.pop1), 32'(p1));
        if (p0) begin
            chk({tag, "_preg0"}, 32'(bus.pop_reg_addr0), 32'(q[0].rg));
            chk({tag, "_prob0"}, 32'(bus.pop_rob_addr0), 32'(mhead));
            chk({tag, "_pdat0"}, bus.pop_data0, q[0].data);
        end
        if (p1) begin
            chk({tag, "_preg1"}, 32'(bus.pop_reg_addr1), 32'(q[1].rg));
            chk({tag, "_prob1"}, 32'(bus.pop_rob_addr1), 32'((mhead + 1) % 8));
            chk({tag, "_pdat1"}, bus.pop_data1, q[1].data);
        end
    endtask

    task automatic idle();
        bus.dispatch0 = 1'b0; bus.dispatch1 = 1'b0;
        bus.dispatch_reg0 = '0; bus.dispatch_reg1 = '0;
        bus.complete0 = 1'b0; bus.complete1 = 1'b0;
        bus.complete_idx0 = '0; bus.complete_idx1 = '0;
        bus.complete_data0 = '0; bus.complete_data1 = '0;
        bus.flush = 1'b0; bus.flush_offset = '0;
    endtask

    task automatic step(input string tag);
        model_apply();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready0"}, 32'(bus.ready0), 32'd1);
        chk({tag, "_ready1"}, 32'(bus.ready1), 32'd1);
        chk({tag, "_alloc0"}, 32'(bus.alloc_idx0), 32'd0);
        chk({tag, "_alloc1"}, 32'(bus.alloc_idx1), 32'd1);
        chk({tag, "_oldest"}, 32'(bus.oldest), 32'd0);
        chk({tag, "_pop0"}, 32'(bus.pop0), 32'd0);
        chk({tag, "_pop1"}, 32'(bus.pop1), 32'd0);
        chk({tag, "_preg0"}, 32'(bus.pop_reg_addr0), 32'd0);
        chk({tag, "_prob1"}, 32'(bus.pop_rob_addr1), 32'd0);
        chk({tag, "_pdat0"}, bus.pop_data0, 32'd0);
    endtask

    // Reset is asserted mid-cycle so outputs are sampled with no clock edge in between.
    task automatic do_reset(input string tag);
        idle();
        #2;
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        q.delete();
        mhead = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic disp2(input logic [4:0] r0, input logic [4:0] r1);
        bus.dispatch0 = 1'b1; bus.dispatch_reg0 = r0;
        bus.dispatch1 = 1'b1; bus.dispatch_reg1 = r1;
    endtask

    initial begin
        logic [2:0]  last_idx;
        bit          have_last;
        logic [31:0] seq;
        logic [31:0] next_ret;
        int          sz;

        idle();
        #3;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // First pair of dispatches
        disp2(5'd3, 5'd7);
        chk("first_alloc0", 32'(bus.alloc_idx0), 32'd0);
        chk("first_alloc1", 32'(bus.alloc_idx1), 32'd1);
        step("disp_pair");
        idle();
        chk("after_pair_alloc0", 32'(bus.alloc_idx0), 32'd2);

        // Out-of-order completion, in-order dual retire
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd1; bus.complete_data0 = 32'hAA;
        step("cmp_idx1");
        idle();
        bus.complete1 = 1'b1; bus.complete_idx1 = 3'd0; bus.complete_data1 = 32'hBB;
        step("cmp_idx0");
        idle();
        chk("dual_pop0", 32'(bus.pop0), 32'd1);
        chk("dual_prob0", 32'(bus.pop_rob_addr0), 32'd0);
        chk("dual_pdat0", bus.pop_data0, 32'hBB);
        chk("dual_preg0", 32'(bus.pop_reg_addr0), 32'd3);
        chk("dual_pop1", 32'(bus.pop1), 32'd1);
        chk("dual_prob1", 32'(bus.pop_rob_addr1), 32'd1);
        chk("dual_pdat1", bus.pop_data1, 32'hAA);
        chk("dual_preg1", 32'(bus.pop_reg_addr1), 32'd7);
        step("retire2");
        chk("head_after_retire", 32'(bus.oldest), 32'd2);

        // Same-index completion from both pipes
        bus.dispatch0 = 1'b1; bus.dispatch_reg0 = 5'd9;
        step("disp_one");
        idle();
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd2; bus.complete_data0 = 32'h11;
        bus.complete1 = 1'b1; bus.complete_idx1 = 3'd2; bus.complete_data1 = 32'h22;
        step("cmp_same");
        idle();
        chk("same_idx_pipe1_wins", bus.pop_data0, 32'h22);
        step("retire_same");

        // Fill to eight entries, then push while full
        repeat (4) begin
            disp2(5'($urandom), 5'($urandom));
            step("fill");
        end
        idle();
        chk("full_ready0", 32'(bus.ready0), 32'd0);
        chk("full_ready1", 32'(bus.ready1), 32'd0);
        disp2(5'd1, 5'd2);
        step("disp_full");
        idle();
        chk("full_tail_kept", 32'(bus.alloc_idx0), 32'd3);

        // Count of seven accepts only dispatch0
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd3; bus.complete_data0 = $urandom;
        step("cmp_head");
        idle();
        step("retire_one");
        chk("cnt7_ready0", 32'(bus.ready0), 32'd1);
        chk("cnt7_ready1", 32'(bus.ready1), 32'd0);
        disp2(5'd4, 5'd5);
        step("cnt7_disp2");
        idle();
        chk("cnt7_only_one", 32'(bus.alloc_idx0), 32'd4);
        chk("cnt7_now_full", 32'(bus.ready0), 32'd0);

        // Flush of incomplete entries with head at 6
        do_reset("rst_a");
        repeat (3) begin
            disp2(5'($urandom), 5'($urandom));
            step("pre_flush_fill");
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.complete0 = 1'b1; bus.complete_idx0 = 3'(2 * i);     bus.complete_data0 = $urandom;
            bus.complete1 = 1'b1; bus.complete_idx1 = 3'(2 * i + 1); bus.complete_data1 = $urandom;
            step("pre_flush_cmp");
        end
        idle();
        repeat (2) step("pre_flush_drain");
        chk("flush_head6", 32'(bus.oldest), 32'd6);
        repeat (3) begin
            disp2(5'($urandom), 5'($urandom));
            step("flush_fill");
        end
        idle();
        bus.flush = 1'b1; bus.flush_offset = 3'd2;
        step("flush2");
        idle();
        chk("flush_tail", 32'(bus.alloc_idx0), 32'd1);
        chk("flush_ready1", 32'(bus.ready1), 32'd1);
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd2; bus.complete_data0 = 32'h5A;
        step("cmp_squashed");
        idle();
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd6; bus.complete_data0 = $urandom;
        bus.complete1 = 1'b1; bus.complete_idx1 = 3'd7; bus.complete_data1 = $urandom;
        step("cmp_kept_a");
        idle();
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd0; bus.complete_data0 = $urandom;
        step("cmp_kept_b");
        idle();
        repeat (3) step("post_flush_drain");
        chk("squashed_never_pops", 32'(bus.pop0), 32'd0);
        chk("post_flush_head", 32'(bus.oldest), 32'd1);

        // Flush while the head retires
        do_reset("rst_b");
        repeat (2) begin
            disp2(5'($urandom), 5'($urandom));
            step("fp_fill");
        end
        idle();
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd0; bus.complete_data0 = $urandom;
        step("fp_cmp");
        idle();
        bus.flush = 1'b1; bus.flush_offset = 3'd3;
        step("fp_flush");
        idle();
        chk("fp_head", 32'(bus.oldest), 32'd1);
        chk("fp_tail", 32'(bus.alloc_idx0), 32'd4);
        chk("fp_ready1", 32'(bus.ready1), 32'd1);

        // Continuous dispatch/complete/retire across the wrap point
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd1; bus.complete_data0 = $urandom;
        bus.complete1 = 1'b1; bus.complete_idx1 = 3'd2; bus.complete_data1 = $urandom;
        step("wr_pre_a");
        idle();
        bus.complete0 = 1'b1; bus.complete_idx0 = 3'd3; bus.complete_data0 = $urandom;
        step("wr_pre_b");
        idle();
        repeat (3) step("wr_pre_drain");
        have_last = 1'b0;
        last_idx = '0;
        seq = 32'h1000;
        next_ret = 32'h1000;
        for (int c = 0; c < 24; c++) begin
            idle();
            if (c < 20) begin
                bus.dispatch0 = 1'b1;
                bus.dispatch_reg0 = 5'($urandom);
            end
            if (have_last) begin
                bus.complete0 = 1'b1;
                bus.complete_idx0 = last_idx;
                bus.complete_data0 = seq;
                seq++;
            end
            have_last = (c < 20);
            last_idx = bus.alloc_idx0;
            step("wrap");
            if (bus.pop0) begin
                chk("wrap_order0", bus.pop_data0, next_ret);
                next_ret++;
            end
            if (bus.pop1) begin
                chk("wrap_order1", bus.pop_data1, next_ret);
                next_ret++;
            end
        end
        idle();
        repeat (2) step("wrap_drain");
        chk("wrap_all_retired", next_ret, 32'h1000 + 32'd20);

        // Random traffic
        do_reset("rst_c");
        for (int c = 0; c < 400; c++) begin
            idle();
            sz = q.size();
            bus.dispatch0 = ($urandom % 4) != 0;
            bus.dispatch1 = ($urandom % 2) != 0;
            bus.dispatch_reg0 = 5'($urandom);
            bus.dispatch_reg1 = 5'($urandom);
            bus.complete0 = ($urandom % 2) != 0;
            bus.complete1 = ($urandom % 3) == 0;
            bus.complete_idx0 = (sz > 0 && ($urandom % 4) != 0) ? 3'((mhead + $urandom % sz) % 8) : 3'($urandom);
            bus.complete_idx1 = (sz > 0 && ($urandom % 4) != 0) ? 3'((mhead + $urandom % sz) % 8) : 3'($urandom);
            bus.complete_data0 = $urandom;
            bus.complete_data1 = $urandom;
            if (sz > 0 && ($urandom % 16) == 0) begin
                bus.flush = 1'b1;
                bus.flush_offset = 3'($urandom % sz);
            end
            step("rnd");
        end

        // Asynchronous reset with five entries outstanding
        do_reset("rst_d");
        disp2(5'd1, 5'd2);
        step("ar_fill_a");
        disp2(5'd3, 5'd4);
        step("ar_fill_b");
        idle();
        bus.dispatch0 = 1'b1; bus.dispatch_reg0 = 5'd5;
        step("ar_fill_c");
        idle();
        chk("ar_alloc_before", 32'(bus.alloc_idx0), 32'd5);
        do_reset("async_rst");
        bus.dispatch0 = 1'b1; bus.dispatch_reg0 = 5'd6;
        chk("ar_first_idx", 32'(bus.alloc_idx0), 32'd0);
        step("ar_disp");
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Eight-entry circular reorder buffer that sits directly upstream of the rename table. It allocates ROB indices to dispatched instructions (the rename table's push addresses) and records writeback completion. It retires up to two completed instructions per cycle in program order, driving the rename table's pop ports. On a branch mispredict it squashes every entry younger than the flushing branch.

## Interface
Parameters:
- NUM_ENTRIES, 8: ROB depth; must be a power of two.
- NUM_ENTRIES_LOG2, 3: index width.
- REG_ADDR_W, 5: architectural register address width.
- DATA_W, 32: result data width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately.
- dispatch0  in  1  allocate one entry for the older dispatching instruction.
- dispatch_reg0  in  REG_ADDR_W  destination register of dispatch0.
- dispatch1  in  1  allocate a second entry; legal only with dispatch0 = 1.
- dispatch_reg1  in  REG_ADDR_W  destination register of dispatch1.
- alloc_idx0  out  NUM_ENTRIES_LOG2  index given to dispatch0 (= tail).
- alloc_idx1  out  NUM_ENTRIES_LOG2  index given to dispatch1 (= tail+1 mod 8).
- ready0  out  1  at least 1 free entry.
- ready1  out  1  at least 2 free entries.
- complete0, complete1  in  1  writeback valid, one per execution pipe.
- complete_idx0, complete_idx1  in  NUM_ENTRIES_LOG2  ROB index being completed.
- complete_data0, complete_data1  in  DATA_W  result value.
- pop0, pop1  out  1  retire the head entry; retire head+1.
- pop_reg_addr0, pop_reg_addr1  out  REG_ADDR_W  destination register of each retiring entry.
- pop_rob_addr0, pop_rob_addr1  out  NUM_ENTRIES_LOG2  ROB index of each retiring entry.
- pop_data0, pop_data1  out  DATA_W  result of each retiring entry.
- oldest  out  NUM_ENTRIES_LOG2  current head index, fed to the rename table's oldest0.
- flush  in  1  mispredict squash.
- flush_offset  in  NUM_ENTRIES_LOG2  offset of the flushing branch from head; 0 = oldest.

## Operation

State:
- head, tail: 3-bit pointers; wrap naturally mod 8.
- count: 4-bit occupancy, range 0..8.
- Per entry: valid, done, reg, data.

Dispatch:
- Accepted only if dispatch0 && ready0.
- dispatch1 is accepted only if dispatch0 is also accepted and ready1 = 1.
- dispatch1 without dispatch0 is ignored.
- An accepted entry gets valid=1, done=0, and reg from its dispatch port.
- tail and count advance by the number of accepted dispatches.

Completion:
- If entry[complete_idx].valid, set done=1 and write data.
- Completion to an invalid (squashed or empty) entry is ignored.
- complete0 and complete1 to the same index: pipe1 data wins.

Retire (combinational from registered state):
- pop0 = entry[head].valid && entry[head].done.
- pop1 = pop0 && entry[head+1].valid && entry[head+1].done.
- Retired entries get valid=0; head advances by pop0+pop1.
- Retire never depends on same-cycle completion.

Flush:
- Entries at offsets 0..flush_offset from head are kept; all younger entries get valid=0.
- tail <= head + flush_offset + 1.
- count <= flush_offset + 1 − retired_this_cycle.
- Retire proceeds normally in the flush cycle; flush_offset refers to the pre-retire head.
- Dispatch is ignored in the flush cycle; ready0 and ready1 still reflect pre-flush count.
- A flush_offset ≥ count is illegal (the driver guarantees it); behaviour is unspecified.

Simultaneous events:
- Dispatch plus retire in the same cycle: count_next = count + accepted − retired.
- A full ROB with retire in the same cycle does not accept dispatch; ready0 and ready1 use the current count.

## Timing
- Reset values:
  - head=0, tail=0, count=0, all valid/done=0.
  - alloc_idx0=0, alloc_idx1=1, ready0=1, ready1=1.
  - pop0=0, pop1=0, pop_*=0, oldest=0.
- alloc_idx, ready, pop_*, and oldest are combinational from registered state; zero input-to-output paths except through state.
- Dispatch at cycle N: entry is valid from N+1; earliest legal completion is N+1.
- Completion at cycle N: pop is visible at N+1 (1-cycle completion-to-retire latency).
- Flush at N: ready0 and ready1 reflect the shrunken count at N+1.
- Reset asserted mid-operation: all state clears asynchronously; the first dispatch after deassertion gets index 0.

## Test plan
- Reset, then dispatch0+dispatch1 (regs 3, 7) -> alloc_idx 0/1; next cycle count=2, alloc_idx0=2.
- Fill 8 entries -> ready0=0, ready1=0; further dispatch ignored, tail unchanged.
- At count=7 -> ready0=1, ready1=0; dispatching both accepts only dispatch0.
- Complete idx1 then idx0 (data 0xAA, 0xBB) -> next cycle pop0=1 (rob 0, data 0xBB), pop1=1 (rob 1, data 0xAA); head=2.
- Head=6, count=6, all incomplete; flush_offset=2 -> next cycle tail=1, count=3; completion to idx 2 is ignored and never retires.
- Flush with pop0 in the same cycle, head=0, flush_offset=3 -> head=1, count=3, tail=4.
- Wrap-around: retire and dispatch continuously for 20 cycles -> indices wrap 7->0; pop order matches dispatch order.
- Assert reset with count=5 -> outputs return to reset values immediately, without waiting for clk.
